mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------------------------------------------------------------------
// Purpose: executes one byte, halfword or word load/store at a time against an
// external word-organised memory. Sub-word stores use read-modify-write.
// Misaligned, illegal-size and out-of-range requests are answered with an error
// and never touch the memory.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only while idle
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned      zero-extend sub-word loads (0 = sign-extend)
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          request rejected without a memory access
//   mem_wr            memory write strobe
//   mem_address       word index (req_addr >> 2)
//   mem_data_in       full word to write
//   mem_data_out      memory read word, refreshed on falling clk while mem_wr=0
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MEM_WORDS = 100,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int LANES = DATA_W / 8;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [DATA_W-1:0] MEM_WORDS_W = DATA_W'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [1:0]        off_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [DATA_W-1:0] resp_rdata_reg;
  logic              mem_wr_reg;
  logic [DATA_W-1:0] mem_address_reg;
  logic [DATA_W-1:0] mem_data_in_reg;

  assign req_ready   = req_ready_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_err    = resp_err_reg;
  assign resp_rdata  = resp_rdata_reg;
  assign mem_wr      = mem_wr_reg;
  assign mem_address = mem_address_reg;
  assign mem_data_in = mem_data_in_reg;

  // -------------------------------------------------------------------------
  // Acceptance-time decode
  // -------------------------------------------------------------------------
  logic              accept;
  logic [DATA_W-1:0] req_index;
  logic              req_err;

  assign accept    = req_valid && req_ready_reg;
  assign req_index = req_addr >> 2;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_index >= MEM_WORDS_W) begin
      req_err = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Byte-lane views of the read word (little-endian)
  // -------------------------------------------------------------------------
  logic [7:0]        rd_lane [LANES];
  logic [LANES-1:0]  lane_en;
  logic [DATA_W-1:0] wr_repl;
  logic [DATA_W-1:0] merged;

  // Store data is right-aligned; replicating it across the word puts the
  // correct bytes on every candidate lane so only the lane enables differ.
  always_comb begin
    wr_repl = wdata_reg;
    case (size_reg)
      SZ_BYTE: wr_repl = {LANES{wdata_reg[7:0]}};
      SZ_HALF: wr_repl = {(LANES/2){wdata_reg[15:0]}};
      default: wr_repl = wdata_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_lane[gi] = mem_data_out[8*gi +: 8];
      assign lane_en[gi] = (size_reg == SZ_BYTE) ? (off_reg == 2'(gi)) :
                           (size_reg == SZ_HALF) ? (off_reg[1] == 1'(gi / 2)) :
                           1'b1;
      assign merged[8*gi +: 8] = lane_en[gi] ? wr_repl[8*gi +: 8]
                                             : mem_data_out[8*gi +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Load extraction: addressed lanes moved to bit 0, then extended
  // -------------------------------------------------------------------------
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_data;

  assign sel_byte = rd_lane[off_reg];
  assign sel_half = {rd_lane[{off_reg[1], 1'b1}], rd_lane[{off_reg[1], 1'b0}]};

  always_comb begin
    load_data = mem_data_out;
    case (size_reg)
      SZ_BYTE: load_data = {{(DATA_W-8){sel_byte[7] & ~unsigned_reg}}, sel_byte};
      SZ_HALF: load_data = {{(DATA_W-16){sel_half[15] & ~unsigned_reg}}, sel_half};
      default: load_data = mem_data_out;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      we_reg          <= 1'b0;
      size_reg        <= 2'b00;
      unsigned_reg    <= 1'b0;
      off_reg         <= 2'b00;
      wdata_reg       <= '0;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_err_reg    <= 1'b0;
      resp_rdata_reg  <= '0;
      mem_wr_reg      <= 1'b0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg        <= req_we;
            size_reg      <= req_size;
            unsigned_reg  <= req_unsigned;
            off_reg       <= req_addr[1:0];
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            if (req_err) begin
              // Rejected requests go straight to the response, memory untouched.
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else begin
              mem_address_reg <= req_index;
              if (req_we && (req_size == SZ_WORD)) begin
                // A full word needs no read of the old contents.
                state_reg       <= WR;
                mem_wr_reg      <= 1'b1;
                mem_data_in_reg <= req_wdata;
              end else begin
                state_reg <= RD;
              end
            end
          end
        end

        RD: begin
          // mem_data_out was refreshed on the falling edge inside this cycle.
          if (we_reg) begin
            state_reg       <= WR;
            mem_wr_reg      <= 1'b1;
            mem_data_in_reg <= merged;
          end else begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= load_data;
          end
        end

        WR: begin
          state_reg      <= RESP;
          mem_wr_reg     <= 1'b0;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end

        RESP: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end

        default: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          mem_wr_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit with a behavioural word memory, a queue
// of expected responses, and immediate assertions at every comparison.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;

  logic [31:0] mem [0:MEM_WORDS-1] = '{default: '0};
  int          wr_count = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Behavioural memory: writes on the rising edge, read port refreshed on the
  // falling edge while no write is strobed.
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_address < MEM_WORDS) mem[mem_address[6:0]] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  always @(negedge clk) begin
    if (!mem_wr) begin
      mem_data_out <= (mem_address < MEM_WORDS) ? mem[mem_address[6:0]] : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request starting at a falling edge; returns at the falling edge
  // after the response pulse, with the block idle again.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input int exp_writes, input bit hold);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    int   w0;
    logic        obs_err;
    logic [31:0] obs_rdata;
    e.tag = tag; e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat; e.writes = exp_writes;
    sb.push_back(e);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w0 = wr_count;
    @(posedge clk);
    #1;
    if (hold) begin
      // Keep offering a different store while busy; it must be ignored.
      req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0; seen = 1'b0; obs_err = 1'bx; obs_rdata = 'x;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        seen = 1'b1; obs_err = resp_err; obs_rdata = resp_rdata;
      end else if (hold) begin
        chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      end
    end
    req_valid = 1'b0;
    got = sb.pop_front();
    chk({got.tag, "_resp_seen"}, 32'(seen), 32'd1);
    chk({got.tag, "_err"}, 32'(obs_err), 32'(got.err));
    chk({got.tag, "_rdata"}, obs_rdata, got.rdata);
    chk({got.tag, "_latency"}, 32'(lat), 32'(got.lat));
    $display("txn %s we=%0b size=%0b uns=%0b addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d",
             tag, we, size, uns, addr, wdata, obs_err, obs_rdata, lat);
    @(negedge clk);
    chk({got.tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    chk({got.tag, "_writes"}, 32'(wr_count - w0), 32'(got.writes));
  endtask

  initial begin
    int  w0;
    bit  seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    @(negedge clk);

    // Word store / load
    do_req("st_w_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 1'b0);
    chk("mem4_after_st_w", mem[4], 32'hDEADBEEF);
    do_req("ld_w_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0, 1'b0);

    // Byte store read-modify-write
    do_req("st_b_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 1'b0, 32'h0, 3, 1, 1'b0);
    chk("mem4_after_st_b", mem[4], 32'hDEAD55EF);

    // Sub-word loads, signed and unsigned
    do_req("ld_hs_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 0, 1'b0);
    do_req("ld_bu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2, 0, 1'b0);
    do_req("ld_bs_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000055, 2, 0, 1'b0);
    do_req("ld_bs_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2, 0, 1'b0);
    do_req("ld_hu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h000055EF, 2, 0, 1'b0);
    do_req("ld_bu_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000000AD, 2, 0, 1'b0);

    // Halfword and byte stores into mem[5] (initially 0), with upper garbage
    do_req("st_h_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234ABCD, 1'b0, 32'h0, 3, 1, 1'b0);
    chk("mem5_after_st_h", mem[5], 32'hABCD0000);
    do_req("st_b_14", 1'b1, 2'b00, 1'b0, 32'h14, 32'hFFFFFF99, 1'b0, 32'h0, 3, 1, 1'b0);
    chk("mem5_after_st_b", mem[5], 32'hABCD0099);
    do_req("ld_w_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hABCD0099, 2, 0, 1'b0);
    do_req("ld_hs_14", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 32'h00000099, 2, 0, 1'b0);

    // Error cases: one-cycle latency, no memory write
    do_req("err_ld_w_02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1, 0, 1'b0);
    do_req("err_ld_h_01", 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b1, 32'h0, 1, 0, 1'b0);
    do_req("err_size_11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 1'b0);
    do_req("err_ld_w_400", 1'b0, 2'b10, 1'b0, 32'd400, 32'h0, 1'b1, 32'h0, 1, 0, 1'b0);
    do_req("err_st_b_401", 1'b1, 2'b00, 1'b0, 32'd401, 32'h11, 1'b1, 32'h0, 1, 0, 1'b0);
    do_req("err_st_h_15", 1'b1, 2'b01, 1'b0, 32'h15, 32'h2222, 1'b1, 32'h0, 1, 0, 1'b0);
    chk("mem5_after_errs", mem[5], 32'hABCD0099);

    // Last legal word index
    do_req("st_w_396", 1'b1, 2'b10, 1'b0, 32'd396, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1, 1'b0);
    do_req("ld_w_396", 1'b0, 2'b10, 1'b0, 32'd396, 32'h0, 1'b0, 32'hCAFEF00D, 2, 0, 1'b0);

    // Requests offered while busy are ignored
    do_req("ld_w_10_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 2, 0, 1'b1);
    repeat (2) @(negedge clk);
    chk("mem8_untouched", mem[8], 32'h0);

    // Reset pulse during the RD cycle of a sub-word store
    w0 = wr_count;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rmw_in_rd_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmw_rel_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk("rmw_no_resp", 32'(seen), 32'd0);
    chk("rmw_no_write", 32'(wr_count - w0), 32'd0);
    chk("rmw_mem4_kept", mem[4], 32'hDEAD55EF);
    $display("txn rst_during_rd resp_seen=%0b writes=%0d mem4=%h", seen, wr_count - w0, mem[4]);

    // Normal operation resumes after the aborted request
    do_req("ld_w_10_post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
